vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator and pixel gate for any resolution/refresh.

---
 rtl/vga_timing_gen.sv | 205 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose
//   Parametrised VGA timing generator and pixel gate. Two free-running counters
//   (h/v) sweep the whole frame including blanking. All DAC-facing outputs are
//   registered one enabled cycle after the counter value they were decoded
//   from. pos_x/pos_y show the live counters so the frame buffer can present
//   pixel_in for that position in the same cycle.
//
// Optional feature
//   VGA_TEST_PATTERN_EN : adds input test_mode. When high, pixel_in is ignored
//   and eight vertical colour bars are generated across the visible width.
//
// Ports
//   clk          in   1        system clock
//   rst          in   1        synchronous active-low reset (wins over en)
//   en           in   1        pixel-clock enable; state advances only when 1
//   test_mode    in   1        colour-bar select (VGA_TEST_PATTERN_EN only)
//   pixel_in     in   PIXEL_W  colour for pos_x/pos_y, valid in the same cycle
//   pos_x        out  CNT_W    horizontal counter (next pixel)
//   pos_y        out  CNT_W    vertical counter (next line)
//   pixel_out    out  PIXEL_W  registered colour, 0 while blanked
//   hsync        out  1        registered horizontal sync, level H_SYNC_POL
//   vsync        out  1        registered vertical sync, level V_SYNC_POL
//   de           out  1        registered data-enable (visible region)
//   line_start   out  1        one-clk pulse: outputs show pixel x=0
//   frame_start  out  1        one-clk pulse: outputs show pixel (0,0)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_VISIBLE  = 32'sd640,
    parameter int   H_FRONT    = 32'sd16,
    parameter int   H_SYNC     = 32'sd96,
    parameter int   H_BACK     = 32'sd48,
    parameter int   V_VISIBLE  = 32'sd480,
    parameter int   V_FRONT    = 32'sd10,
    parameter int   V_SYNC     = 32'sd2,
    parameter int   V_BACK     = 32'sd33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   PIXEL_W    = 32'sd3,
    parameter int   CNT_W      = 32'sd11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic [CNT_W-1:0]   pos_x,
    output logic [CNT_W-1:0]   pos_y,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 32'sd1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 32'sd1);

    // Window bounds are compared one bit wider than the counters so that an
    // end bound equal to TOTAL (zero back porch) cannot wrap to zero.
    localparam logic [CNT_W:0] H_VIS_W   = (CNT_W + 32'sd1)'(H_VISIBLE);
    localparam logic [CNT_W:0] V_VIS_W   = (CNT_W + 32'sd1)'(V_VISIBLE);
    localparam logic [CNT_W:0] HS_STRT_W = (CNT_W + 32'sd1)'(HS_START);
    localparam logic [CNT_W:0] HS_END_W  = (CNT_W + 32'sd1)'(HS_END);
    localparam logic [CNT_W:0] VS_STRT_W = (CNT_W + 32'sd1)'(VS_START);
    localparam logic [CNT_W:0] VS_END_W  = (CNT_W + 32'sd1)'(VS_END);

    logic [CNT_W-1:0]   hCnt_r;
    logic [CNT_W-1:0]   vCnt_r;
    logic [PIXEL_W-1:0] pixel_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               de_r;
    logic               lineStart_r;
    logic               frameStart_r;

    logic [CNT_W-1:0]   hCntNext_s;
    logic [CNT_W-1:0]   vCntNext_s;
    logic [CNT_W:0]     hExt_s;
    logic [CNT_W:0]     vExt_s;
    logic               deNext_s;
    logic               hsyncNext_s;
    logic               vsyncNext_s;
    logic [PIXEL_W-1:0] pixelNext_s;

`ifdef VGA_TEST_PATTERN_EN
    localparam int SLICE_W = PIXEL_W / 32'sd3;

    logic [CNT_W+2:0]   barNum_s;
    logic [2:0]         bar_s;
    logic [PIXEL_W-1:0] pattern_s;
`endif

    // Counter successor: h wraps at H_TOTAL-1 and carries into v, v wraps at V_TOTAL-1.
    always_comb begin
        hCntNext_s = hCnt_r;
        vCntNext_s = vCnt_r;
        if (hCnt_r == H_LAST) begin
            hCntNext_s = CNT_ZERO;
            if (vCnt_r == V_LAST) begin
                vCntNext_s = CNT_ZERO;
            end else begin
                vCntNext_s = vCnt_r + CNT_ONE;
            end
        end else begin
            hCntNext_s = hCnt_r + CNT_ONE;
            vCntNext_s = vCnt_r;
        end
    end

    // Region decode of the current counters into next-cycle DE and sync levels.
    always_comb begin
        hExt_s      = {1'b0, hCnt_r};
        vExt_s      = {1'b0, vCnt_r};
        deNext_s    = (hExt_s < H_VIS_W) && (vExt_s < V_VIS_W);
        hsyncNext_s = ~H_SYNC_POL;
        vsyncNext_s = ~V_SYNC_POL;
        if ((hExt_s >= HS_STRT_W) && (hExt_s < HS_END_W)) begin
            hsyncNext_s = H_SYNC_POL;
        end else begin
            hsyncNext_s = ~H_SYNC_POL;
        end
        // v_cnt only changes together with h_cnt wrapping to 0, so vsync
        // edges land on line boundaries without extra logic.
        if ((vExt_s >= VS_STRT_W) && (vExt_s < VS_END_W)) begin
            vsyncNext_s = V_SYNC_POL;
        end else begin
            vsyncNext_s = ~V_SYNC_POL;
        end
    end

    // Pixel source select and blanking gate.
    always_comb begin
        pixelNext_s = {PIXEL_W{1'b0}};
`ifdef VGA_TEST_PATTERN_EN
        // Bar index = h*8/H_VISIBLE; the divisor is a constant.
        barNum_s  = {hCnt_r, 3'b000};
        bar_s     = 3'(barNum_s / (CNT_W + 32'sd3)'(H_VISIBLE));
        pattern_s = {{SLICE_W{bar_s[2]}}, {SLICE_W{bar_s[1]}}, {SLICE_W{bar_s[0]}}};
`endif
        if (deNext_s) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                pixelNext_s = pattern_s;
            end else begin
                pixelNext_s = pixel_in;
            end
`else
            pixelNext_s = pixel_in;
`endif
        end else begin
            pixelNext_s = {PIXEL_W{1'b0}};
        end
    end

    // State and output registers; pulses are cleared on every non-enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hCnt_r       <= CNT_ZERO;
            vCnt_r       <= CNT_ZERO;
            pixel_r      <= {PIXEL_W{1'b0}};
            hsync_r      <= ~H_SYNC_POL;
            vsync_r      <= ~V_SYNC_POL;
            de_r         <= 1'b0;
            lineStart_r  <= 1'b0;
            frameStart_r <= 1'b0;
        end else if (en) begin
            hCnt_r       <= hCntNext_s;
            vCnt_r       <= vCntNext_s;
            pixel_r      <= pixelNext_s;
            hsync_r      <= hsyncNext_s;
            vsync_r      <= vsyncNext_s;
            de_r         <= deNext_s;
            lineStart_r  <= (hCnt_r == CNT_ZERO);
            frameStart_r <= (hCnt_r == CNT_ZERO) && (vCnt_r == CNT_ZERO);
        end else begin
            lineStart_r  <= 1'b0;
            frameStart_r <= 1'b0;
        end
    end

    assign pos_x       = hCnt_r;
    assign pos_y       = vCnt_r;
    assign pixel_out   = pixel_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign line_start  = lineStart_r;
    assign frame_start = frameStart_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen using a tiny 15x8 frame
// (H 8/2/3/2, V 4/1/2/1, PIXEL_W 3, active-low syncs). Expected values come
// from the timing parameters: an enabled edge taken with the counters at
// linear position t (x = t%15, y = (t/15)%8) leaves the registered outputs
// decoded from (x,y) and the counters at position t+1.
// With VGA_TEST_PATTERN_EN a second 640x480 instance checks the colour bars.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    pixelIn;
    logic [CW-1:0] posX;
    logic [CW-1:0] posY;
    logic [2:0]    pixelOut;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          lineStart;
    logic          frameStart;

    int checks   = 0;
    int failures = 0;
    int n;
    int lastT;
    logic [2:0] lastPix;

    always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
    logic tm0 = 1'b0;
`endif

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIXEL_W(3), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm0),
`endif
        .pixel_in(pixelIn),
        .pos_x(posX),
        .pos_y(posY),
        .pixel_out(pixelOut),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .line_start(lineStart),
        .frame_start(frameStart)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic        tpRst;
    logic        tpEn;
    logic        tpMode;
    logic [2:0]  tpPixIn;
    logic [10:0] tpX;
    logic [10:0] tpY;
    logic [2:0]  tpPix;
    logic        tpH;
    logic        tpV;
    logic        tpDe;
    logic        tpLs;
    logic        tpFs;

    vga_timing_gen #(.H_SYNC_POL(1'b1)) tp (
        .clk(clk),
        .rst(tpRst),
        .en(tpEn),
        .test_mode(tpMode),
        .pixel_in(tpPixIn),
        .pos_x(tpX),
        .pos_y(tpY),
        .pixel_out(tpPix),
        .hsync(tpH),
        .vsync(tpV),
        .de(tpDe),
        .line_start(tpLs),
        .frame_start(tpFs)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".pos_x"}, 32'(posX), 32'd0);
        check({tag, ".pos_y"}, 32'(posY), 32'd0);
        check({tag, ".de"}, 32'(de), 32'd0);
        check({tag, ".pixel_out"}, 32'(pixelOut), 32'd0);
        check({tag, ".hsync"}, 32'(hsync), 32'd1);
        check({tag, ".vsync"}, 32'(vsync), 32'd1);
        check({tag, ".line_start"}, 32'(lineStart), 32'd0);
        check({tag, ".frame_start"}, 32'(frameStart), 32'd0);
    endtask

    // t: linear position the registered outputs were decoded from;
    // cnt: linear position the counters now hold; pulses: last edge enabled.
    task automatic expectState(input int t, input logic [2:0] pix, input bit pulses, input int cnt);
        int x;
        int y;
        bit vis;
        x   = t % 15;
        y   = (t / 15) % 8;
        vis = (x < 8) && (y < 4);
        check("de", 32'(de), 32'(vis));
        check("pixel_out", 32'(pixelOut), vis ? 32'(pix) : 32'd0);
        check("hsync", 32'(hsync), (x >= 10 && x < 13) ? 32'd0 : 32'd1);
        check("vsync", 32'(vsync), (y >= 5 && y < 7) ? 32'd0 : 32'd1);
        check("line_start", 32'(lineStart), 32'(pulses && x == 0));
        check("frame_start", 32'(frameStart), 32'(pulses && x == 0 && y == 0));
        check("pos_x", 32'(posX), 32'(cnt % 15));
        check("pos_y", 32'(posY), 32'((cnt / 15) % 8));
    endtask

    initial begin
`ifdef VGA_TEST_PATTERN_EN
        tpRst   = 1'b0;
        tpEn    = 1'b1;
        tpMode  = 1'b1;
        tpPixIn = 3'b000;
`endif
        // Reset held for 3 clocks with en high.
        rst     = 1'b0;
        en      = 1'b1;
        pixelIn = 3'b101;
        repeat (3) tick();
        checkReset("reset");

        // Free run for two whole frames (240 clocks) with varying pixel data.
        rst = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            pixelIn = 3'(k * 3 + 2);
            tick();
            expectState(k - 1, pixelIn, 1'b1, k);
        end

        // en toggling 1,0,1,0: counters step every other clock, regs hold,
        // pulses stay one clock wide; pixel_in flips on held cycles.
        n       = 240;
        lastT   = 239;
        lastPix = pixelIn;
        for (int j = 0; j < 250; j++) begin
            en = (j % 2 == 0);
            if (en) begin
                pixelIn = 3'(j + 1);
            end else begin
                pixelIn = ~lastPix;
            end
            tick();
            if (en) begin
                expectState(n, pixelIn, 1'b1, n + 1);
                lastT   = n;
                lastPix = pixelIn;
                n++;
            end else begin
                expectState(lastT, lastPix, 1'b0, n);
            end
        end

        // Run on to (x=5, y=2), then pulse reset for one clock.
        en = 1'b1;
        for (int g = 0; g < 120 && (n % 120) != 35; g++) begin
            pixelIn = 3'(n);
            tick();
            expectState(n, pixelIn, 1'b1, n + 1);
            n++;
        end
        check("midframe.pos_x", 32'(posX), 32'd5);
        check("midframe.pos_y", 32'(posY), 32'd2);
        rst = 1'b0;
        tick();
        checkReset("midreset");
        rst     = 1'b1;
        pixelIn = 3'b110;
        tick();
        expectState(0, 3'b110, 1'b1, 1);
        tick();
        expectState(1, 3'b110, 1'b1, 2);

        // Reset wins over en=0.
        rst = 1'b0;
        en  = 1'b0;
        tick();
        checkReset("reset_en0");
        rst = 1'b1;
        tick();
        checkReset("hold_after_reset");
        en = 1'b1;
        tick();
        expectState(0, 3'b110, 1'b1, 1);

`ifdef VGA_TEST_PATTERN_EN
        // 640x480 colour bars over one full line, hsync active-high.
        tpRst = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            check("tp.pixel_out", 32'(tpPix), (k - 1) < 640 ? 32'((k - 1) / 80) : 32'd0);
            check("tp.hsync", 32'(tpH), ((k - 1) >= 656 && (k - 1) < 752) ? 32'd1 : 32'd0);
        end
        tpMode  = 1'b0;
        tpPixIn = 3'b011;
        tick();
        check("tp.passthrough", 32'(tpPix), 32'd3);
        tpMode = 1'b1;
        tick();
        check("tp.bar0_again", 32'(tpPix), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
